// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - background, CPU and VRAM-side signal bundle for vram_arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              bgReq;
  logic [ADDR_W-1:0] bgAddr;
  logic [DATA_W-1:0] bgData;
  logic              bgDataValid;
  logic              cpuReq;
  logic              cpuWe;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWData;
  logic              cpuAck;
  logic [DATA_W-1:0] cpuRData;
  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [DATA_W-1:0] memWData;
  logic [DATA_W-1:0] memRData;

  modport master (
    output bgReq, bgAddr, cpuReq, cpuWe, cpuAddr, cpuWData, memRData,
    input  bgData, bgDataValid, cpuAck, cpuRData, memAddr, memWe, memWData
  );

  modport slave (
    input  bgReq, bgAddr, cpuReq, cpuWe, cpuAddr, cpuWData, memRData,
    output bgData, bgDataValid, cpuAck, cpuRData, memAddr, memWe, memWData
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM scheduler: background fetch first, CPU in idle slots
// Optional one-entry posted-write buffer enabled by VRAM_ARB_POSTED_WRITE_EN.
module vram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              hold_we;
  logic              ack_q;
  logic              bg_valid_q;
  logic              cpu_issue;

`ifdef VRAM_ARB_POSTED_WRITE_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_drain;
  logic              post_write;

  assign buf_drain  = buf_valid && !bus.bgReq;
  // WAIT accesses stay behind a pending posted write so read-after-write order holds
  assign cpu_issue  = (state == WAIT) && !bus.bgReq && !buf_valid;
  assign post_write = bus.cpuWe && !buf_valid;
`else
  assign cpu_issue  = (state == WAIT) && !bus.bgReq;
`endif

  always_comb begin
    bus.memAddr  = hold_addr;
    bus.memWe    = 1'b0;
    bus.memWData = hold_data;
    if (bus.bgReq) begin
      bus.memAddr = bus.bgAddr;
`ifdef VRAM_ARB_POSTED_WRITE_EN
    end else if (buf_valid) begin
      bus.memAddr  = buf_addr;
      bus.memWe    = 1'b1;
      bus.memWData = buf_data;
`endif
    end else if (cpu_issue) begin
      bus.memWe = hold_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_we    <= 1'b0;
      ack_q      <= 1'b0;
      bg_valid_q <= 1'b0;
`ifdef VRAM_ARB_POSTED_WRITE_EN
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
`endif
    end else begin
      bg_valid_q <= bus.bgReq;
      ack_q      <= 1'b0;
`ifdef VRAM_ARB_POSTED_WRITE_EN
      if (buf_drain) buf_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.cpuReq) begin
            hold_addr <= bus.cpuAddr;
            hold_data <= bus.cpuWData;
            hold_we   <= bus.cpuWe;
`ifdef VRAM_ARB_POSTED_WRITE_EN
            if (post_write) begin
              buf_valid <= 1'b1;
              buf_addr  <= bus.cpuAddr;
              buf_data  <= bus.cpuWData;
              state     <= DONE;
              ack_q     <= 1'b1;
            end else begin
              state <= WAIT;
            end
`else
            state <= WAIT;
`endif
          end
        end
        WAIT: begin
          if (cpu_issue) begin
            state <= DONE;
            ack_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bgData      = bus.memRData;
  assign bus.bgDataValid = bg_valid_q;
  assign bus.cpuAck      = ack_q;
  // writes return zero; read data arrives from VRAM exactly in the ack cycle
  assign bus.cpuRData    = (ack_q && !hold_we) ? bus.memRData : '0;
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access scheduler. The background fetch pipeline has absolute priority on every cycle it requests. A CPU-side requester gets the remaining idle slots through a req/ack handshake. Sits between the background control/fetch logic and the one synchronous VRAM macro, so background timing is never disturbed by CPU traffic.

## Interface
Parameters:
- `ADDR_W`, 16, VRAM address width
- `DATA_W`, 8, VRAM data width

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `bgReq`  in  1  background fetch this cycle (OR of the pipeline's address strobes)
- `bgAddr`  in  ADDR_W  background fetch address, valid with `bgReq`
- `bgData`  out  DATA_W  equals `memRData`, combinational pass-through
- `bgDataValid`  out  1  `bgReq` delayed one cycle
- `cpuReq`  in  1  CPU access request, held until `cpuAck`
- `cpuWe`  in  1  1 = write, 0 = read; stable while `cpuReq`
- `cpuAddr`  in  ADDR_W  CPU address; stable while `cpuReq`
- `cpuWData`  in  DATA_W  CPU write data; stable while `cpuReq`
- `cpuAck`  out  1  one-cycle completion pulse
- `cpuRData`  out  DATA_W  read data, valid only while `cpuAck` on a read, else 0
- `memAddr`  out  ADDR_W  VRAM address
- `memWe`  out  1  VRAM write enable
- `memWData`  out  DATA_W  VRAM write data
- `memRData`  in  DATA_W  VRAM read data, one cycle after `memAddr`

## Operation
- Slot owner, decided each cycle in this priority order:
  1. `bgReq`
  2. posted-write buffer (only with the Configuration macro)
  3. CPU hold register in WAIT
  4. none
- Background slot:
  - `memAddr=bgAddr`, `memWe=0`.
  - Never delayed, never blocked.
- CPU FSM states: IDLE, WAIT, DONE.
  - IDLE: if `cpuReq`, capture `cpuAddr`/`cpuWe`/`cpuWData` into hold registers and go to WAIT.
  - WAIT: if `!bgReq` (and no buffer drain pending), drive `memAddr`/`memWe`/`memWData` from the hold registers and go to DONE. Otherwise stay in WAIT.
  - DONE: `cpuAck=1`; `cpuRData=memRData` for reads, 0 for writes; go to IDLE.
- Requester rule: deassert `cpuReq`, or present a new request, in the cycle after `cpuAck`. `cpuReq` is ignored in WAIT and DONE.
- Idle slot (none owns it): `memWe=0`, `memAddr` = hold address, `memWData` = hold data.
- `memWe` is asserted only in a CPU or buffer write issue cycle.
- Reset values: state IDLE; hold registers 0; `cpuAck=0`, `cpuRData=0`, `bgDataValid=0`, `memWe=0`. With `bgReq=0`, `memAddr=0` and `memWData=0`.
- Reset mid-operation: the in-flight CPU access is dropped and no ack is produced. A WAIT-state write never reaches memory. With the buffer enabled, buffer contents are discarded.

## Timing
- Background: `bgReq`/`bgAddr` at cycle N gives `bgDataValid=1` and `bgData` at N+1. Same latency as raw VRAM.
- CPU minimum latency: `cpuReq` first high at cycle 0, issue at cycle 1, `cpuAck` at cycle 2.
- Each cycle `bgReq` is high during WAIT adds one cycle.
- Back-to-back CPU: a new request presented at DONE+1 is captured at that cycle's edge. Throughput is one access per 3 cycles.
- `bgReq` continuously high starves the CPU indefinitely. This is by design; the video timing guarantees free slots.

## Configuration
- `VRAM_ARB_POSTED_WRITE_EN` defined: adds a one-entry posted-write buffer.
  - In IDLE, `cpuReq & cpuWe` with the buffer empty loads the buffer and goes straight to DONE. `cpuAck` is at cycle 1.
  - The buffer drains on the first cycle with `!bgReq`, ahead of the WAIT hold register.
  - A write arriving while the buffer is full, or any read, goes through WAIT. A WAIT access issues only once the buffer is empty, so read-after-write ordering is kept.
- Undefined: no buffer; all CPU accesses use the IDLE→WAIT→DONE path.

## Test plan
- Reset → all outputs 0, state IDLE. Then read at 0x1234 with `memRData` model returning 0xA5 and `bgReq=0` → `memAddr=0x1234` at cycle 1, `cpuAck` plus `cpuRData=0xA5` at cycle 2.
- CPU write 0x0400←0x3C while `bgReq` is high for cycles 1–3 → `memAddr` follows `bgAddr` in cycles 1–3, `memWe=1` with 0x3C only in cycle 4, `cpuAck` in cycle 5, `bgDataValid` in cycles 2–4.
- Background pattern {0,1,2,4} of 12 repeating, with continuous CPU reads → every `bgReq` cycle owns memory, CPU issues only in non-bg cycles, no `cpuAck` overlaps a wrong data return.
- Assert `reset` while in WAIT holding a write → `memWe` never asserts, `cpuAck` stays 0, state IDLE after release.
- With macro: write 0x10←0x55 then read 0x10 while `bgReq` is held high 4 cycles → write `cpuAck` at cycle 1, memory write after `bgReq` drops, read returns 0x55.
- Without macro: same sequence → write `cpuAck` no earlier than cycle 2, read returns 0x55.
